// File: rtl/memory_stream_reader.sv
// Streams a contiguous, wrapping range of memory_block words to a valid/ready consumer.
// A 2-entry FIFO plus a one-deep in-flight tag hide the memory's one-cycle read latency.
module memory_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      length,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_rd_addr,
    input  logic [WIDTH-1:0] mem_rd_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_addr,
    output logic             out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [AW:0]   ONE_L    = (AW+1)'(1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t            state_r;
    state_t            state_n;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       issue_left_r;
    logic [AW:0]       pop_left_r;
    logic              inflight_r;
    logic [AW-1:0]     inflight_addr_r;
    logic [1:0]        count_r;
    logic [WIDTH-1:0]  fifo_data_r [0:1];
    logic [AW-1:0]     fifo_addr_r [0:1];
    logic              accept_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [2:0]        occ_s;

    assign out_valid   = (count_r != 2'd0);
    assign out_data    = fifo_data_r[0];
    assign out_addr    = fifo_addr_r[0];
    assign out_last    = (pop_left_r == ONE_L) & out_valid;
    assign busy        = (state_r != S_IDLE);
    assign done        = (state_r == S_DONE);
    assign mem_rd_addr = rd_ptr_r;

    assign accept_s = (state_r == S_IDLE) & start;
    assign pop_s    = out_valid & out_ready;
    assign push_s   = inflight_r;
    // Credit check: words held plus word in flight, net of this cycle's pop, must leave room.
    assign occ_s    = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s  = (state_r == S_FETCH) & (issue_left_r != '0) & (occ_s < 3'd2);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_n = (length == '0) ? S_DONE : S_FETCH;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_FETCH: begin
                if (pop_s && (pop_left_r == ONE_L)) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Read pointer, command counters and in-flight tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r        <= '0;
            issue_left_r    <= '0;
            pop_left_r      <= '0;
            inflight_r      <= 1'b0;
            inflight_addr_r <= '0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_addr_r <= rd_ptr_r;
            end
            if (accept_s) begin
                rd_ptr_r     <= base_addr;
                issue_left_r <= length;
                pop_left_r   <= length;
            end else begin
                if (issue_s) begin
                    rd_ptr_r     <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + AW'(1);
                    issue_left_r <= issue_left_r - ONE_L;
                end
                if (pop_s) begin
                    pop_left_r <= pop_left_r - ONE_L;
                end
            end
        end
    end

    // Two-entry shift FIFO; entry 0 is always the head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r        <= 2'd0;
            fifo_data_r[0] <= '0;
            fifo_data_r[1] <= '0;
            fifo_addr_r[0] <= '0;
            fifo_addr_r[1] <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    if (count_r == 2'd1) begin
                        fifo_data_r[0] <= mem_rd_dout;
                        fifo_addr_r[0] <= inflight_addr_r;
                    end else begin
                        fifo_data_r[0] <= fifo_data_r[1];
                        fifo_addr_r[0] <= fifo_addr_r[1];
                        fifo_data_r[1] <= mem_rd_dout;
                        fifo_addr_r[1] <= inflight_addr_r;
                    end
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        fifo_data_r[0] <= mem_rd_dout;
                        fifo_addr_r[0] <= inflight_addr_r;
                    end else begin
                        fifo_data_r[1] <= mem_rd_dout;
                        fifo_addr_r[1] <= inflight_addr_r;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    fifo_data_r[0] <= fifo_data_r[1];
                    fifo_addr_r[0] <= fifo_addr_r[1];
                    count_r        <= count_r - 2'd1;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Scoreboard bench for memory_stream_reader: commands push expected words, a negedge
// monitor pops and compares on every handshake and tracks busy/done/latency/stall rules.
module tb_memory_stream_reader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      length;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_rd_addr;
    logic [WIDTH-1:0] mem_rd_dout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic             out_last;

    memory_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_rd_addr(mem_rd_addr), .mem_rd_dout(mem_rd_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 0;
    int   cyc = 0;
    int   hs_count = 0;

    logic [WIDTH-1:0] mem [DEPTH];

    function automatic logic [WIDTH-1:0] word_of(input int a);
        return 32'(a) * 32'h01010101;
    endfunction

    // Synchronous-read memory model standing in for memory_block
    always @(posedge clk) mem_rd_dout <= mem[mem_rd_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer readiness: always, random, or the 1,0,0,1 pattern
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
        end
    end

    // Monitor: handshakes against scoreboard, plus busy/done/latency/stall behaviour
    initial begin
        logic m_busy, m_done, hold, acc, last_hs, nb;
        logic [WIDTH-1:0] hold_d;
        logic [AW-1:0] hold_a;
        int lat;
        exp_t e;
        m_busy = 0; m_done = 0; hold = 0; lat = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_busy = 0; m_done = 0; hold = 0; lat = 0;
            end else begin
                check("busy", busy, m_busy);
                check("done", done, m_done);
                if (lat > 0) begin
                    lat--;
                    check("valid_latency", out_valid, lat == 0);
                end
                if (hold) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, hold_d);
                    check("stall_addr", out_addr, hold_a);
                end
                last_hs = 0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: got addr %0h data %0h expected no word", out_addr, out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_addr", out_addr, e.addr);
                        check("out_last", out_last, e.last);
                        last_hs = e.last;
                        hs_count++;
                    end
                end
                acc = start && !m_busy;
                if (acc) nb = 1;
                else if (m_done) nb = 0;
                else nb = m_busy;
                if (acc && length != 0) lat = 3;
                hold   = out_valid && !out_ready;
                hold_d = out_data;
                hold_a = out_addr;
                m_done = (acc && length == 0) || last_hs;
                m_busy = nb;
            end
        end
    end

    task automatic issue_cmd(input int b, input int len, input bit expect_accept);
        exp_t e;
        if (expect_accept) begin
            for (int k = 0; k < len; k++) begin
                e.addr = AW'((b + k) % DEPTH);
                e.data = word_of((b + k) % DEPTH);
                e.last = (k == len - 1);
                sb.push_back(e);
            end
        end
        start = 1'b1;
        base_addr = AW'(b);
        length = (AW+1)'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || sb.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("cmd_completes", n < limit, 1);
        check("sb_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h0, n;
        for (int i = 0; i < DEPTH; i++) mem[i] = word_of(i);
        rst = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", out_addr, 0);
        check("rst_rdaddr", mem_rd_addr, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        ready_mode = 0;
        issue_cmd(0, 128, 1);
        wait_idle(400);

        issue_cmd(125, 6, 1);
        wait_idle(100);

        ready_mode = 2;
        issue_cmd(10, 8, 1);
        wait_idle(100);

        ready_mode = 0;
        issue_cmd(33, 0, 1);
        wait_idle(20);

        ready_mode = 1;
        issue_cmd(0, 4, 1);
        @(posedge clk);
        #1;
        issue_cmd(50, 7, 0);
        wait_idle(100);

        ready_mode = 0;
        h0 = hs_count;
        issue_cmd(40, 10, 1);
        n = 0;
        while ((hs_count - h0) < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("three_words_seen", n < 100, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_valid", out_valid, 0);
        check("arst_last", out_last, 0);
        check("arst_data", out_data, 0);
        check("arst_addr", out_addr, 0);
        check("arst_rdaddr", mem_rd_addr, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue_cmd(20, 2, 1);
        wait_idle(50);

        for (int c = 0; c < 12; c++) begin
            int b, len;
            ready_mode = $urandom_range(0, 2);
            b = $urandom_range(0, DEPTH - 1);
            len = ($urandom_range(0, 7) == 0) ? DEPTH : $urandom_range(0, 20);
            issue_cmd(b, len, 1);
            wait_idle(700);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
